bp_me_lce_req_arbiter: RTL and testbench
========================================

BP_ME_LCE_REQ_ARBITER -- requirements
Module: bp_me_lce_req_arbiter

Interface
REQ-001 SHALL have parameter num_lce_p, default 2: number of LCE request sources; legal range 1..16.
REQ-002 SHALL have parameter lce_req_width_p, default 128: width of one LCE request message in bits.
REQ-003 SHALL define local id width lg_lce_lp = max(1, ceil(log2(num_lce_p))).
REQ-004 SHALL have port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_i, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port freeze_i, input, 1: when high, no new grants are issued.
REQ-007 SHALL have port lce_req_i, input, num_lce_p*lce_req_width_p: packed requests; source k occupies bits [k*W +: W].
REQ-008 SHALL have port lce_req_v_i, input, num_lce_p: per-source valid.
REQ-009 SHALL have port lce_req_yumi_o, output, num_lce_p: per-source consume strobe, at most one bit set.
REQ-010 SHALL have port lce_req_o, output, lce_req_width_p: buffered request to the CCE.
REQ-011 SHALL have port lce_req_v_o, output, 1: buffered request valid.
REQ-012 SHALL have port lce_req_yumi_i, input, 1: CCE consumes lce_req_o this cycle; legal only while lce_req_v_o=1.
REQ-013 SHALL have port grant_id_o, output, lg_lce_lp: source index of the buffered request.

Function
REQ-014 SHALL hold a one-entry output buffer (data and id) and a two-state FSM: EMPTY (lce_req_v_o=0) and FULL (lce_req_v_o=1).
REQ-015 SHALL define load_ok = !freeze_i & (EMPTY | lce_req_yumi_i).
REQ-016 SHALL, when load_ok and any lce_req_v_i is set, grant the first valid source found scanning upward from rr_ptr with wrap past num_lce_p-1 to 0.
REQ-017 SHALL assert lce_req_yumi_o[g] combinationally in the same cycle as the grant, and assert no other yumi bit.
REQ-018 SHALL never assert any lce_req_yumi_o bit when load_ok=0 or when no source is valid.
REQ-019 SHALL, on a grant, capture lce_req_i[g] and id g into the buffer at the next edge; the FSM goes to FULL and rr_ptr becomes (g+1) mod num_lce_p.
REQ-020 SHALL keep rr_ptr unchanged in any cycle without a grant.
REQ-021 SHALL go FULL->EMPTY on lce_req_yumi_i with no grant, FULL->FULL with a reloaded buffer on lce_req_yumi_i plus a grant, and hold FULL with stable data on no yumi.
REQ-022 SHALL have one cycle of latency from a grant to lce_req_v_o=1 and sustain one request per cycle under continuous yumi.
REQ-023 SHALL hold lce_req_o and grant_id_o stable while FULL and not consumed.
REQ-024 SHALL, while freeze_i=1, still drain a FULL buffer on lce_req_yumi_i and then go to EMPTY.
REQ-025 SHALL, when num_lce_p=1, grant source 0 whenever load_ok and valid, and tie grant_id_o to 0.
REQ-026 SHALL guarantee that a continuously valid source is granted within num_lce_p consecutive grants.
REQ-027 SHALL contain no combinational path from lce_req_i to lce_req_o.

Reset
REQ-028 SHALL, while reset_i=0, force EMPTY, lce_req_v_o=0, rr_ptr=0, grant_id_o=0, lce_req_o=0, and all lce_req_yumi_o=0, regardless of clock.
REQ-029 SHALL discard a buffered request on reset mid-operation; the source is not re-yumied, and recovery belongs to the upstream protocol.
REQ-030 SHALL make no grant in the first cycle after reset deassertion if that deassertion falls within the setup window; grants start from the first full cycle with reset_i=1.

Verification
REQ-031 Single source: num_lce_p=2, only v_i[1]=1 with data 0xA5 and yumi_i held 1 -> yumi_o=2'b10 in cycle 0; lce_req_o=0xA5, v_o=1, grant_id_o=1 in cycle 1; rr_ptr=0.
REQ-032 Round-robin: num_lce_p=4, all v_i=1 continuously, yumi_i=1 -> grant_id_o sequence 0,1,2,3,0,1 on consecutive cycles with v_o never dropping.
REQ-033 Backpressure: FULL with id 2, yumi_i=0 for 5 cycles, all v_i=1 -> no yumi_o bits set and lce_req_o unchanged; on yumi_i=1 the same-cycle grant is id 3.
REQ-034 Freeze: FULL, freeze_i=1, yumi_i=1 -> next cycle v_o=0 and no yumi_o while frozen; freeze_i=0 -> grant on the same cycle.
REQ-035 Async reset: reset_i driven low mid-cycle while FULL -> v_o=0 immediately without a clock edge; after release with v_i=4'b1000, the first grant is id 3.

Source files
------------

// File: rtl/bp_me_lce_req_arbiter.sv
// Round-robin arbiter that picks one LCE request per cycle into a single-entry
// output buffer feeding the CCE.
module bp_me_lce_req_arbiter #(
    parameter int num_lce_p       = 2,
    parameter int lce_req_width_p = 128,
    localparam int lg_lce_lp      = (num_lce_p > 1) ? $clog2(num_lce_p) : 1
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic                                 freeze_i,
    input  logic [num_lce_p*lce_req_width_p-1:0] lce_req_i,
    input  logic [num_lce_p-1:0]                 lce_req_v_i,
    output logic [num_lce_p-1:0]                 lce_req_yumi_o,
    output logic [lce_req_width_p-1:0]           lce_req_o,
    output logic                                 lce_req_v_o,
    input  logic                                 lce_req_yumi_i,
    output logic [lg_lce_lp-1:0]                 grant_id_o
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e                       state_q, state_d;
    logic [lce_req_width_p-1:0]   data_q, data_d;
    logic [lg_lce_lp-1:0]         id_q, id_d;
    logic [lg_lce_lp-1:0]         rr_ptr_q, rr_ptr_d;
    logic                         ready_q, ready_d;

    logic                         load_ok;
    logic                         grant_found;
    logic                         grant;
    logic [lg_lce_lp-1:0]         grant_idx;
    logic [lce_req_width_p-1:0]   grant_data;
    int unsigned                  scan_idx;
    int unsigned                  next_ptr;

    // ready_q holds off grants until the first full cycle after reset release,
    // so a release landing in the setup window cannot produce a grant.
    assign ready_d = 1'b1;

    always_comb begin
        load_ok     = reset_i & ready_q & ~freeze_i &
                      ((state_q == EMPTY) | lce_req_yumi_i);
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        for (int unsigned i = 0; i < num_lce_p; i++) begin
            scan_idx = 32'(rr_ptr_q) + i;
            if (scan_idx >= num_lce_p) begin
                scan_idx = scan_idx - num_lce_p;
            end
            if (!grant_found && lce_req_v_i[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = lg_lce_lp'(scan_idx);
            end
        end
        grant = load_ok & grant_found;

        lce_req_yumi_o = '0;
        grant_data     = '0;
        for (int unsigned k = 0; k < num_lce_p; k++) begin
            if (grant && (grant_idx == lg_lce_lp'(k))) begin
                lce_req_yumi_o[k] = 1'b1;
                grant_data        = lce_req_i[k*lce_req_width_p +: lce_req_width_p];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        id_d     = id_q;
        rr_ptr_d = rr_ptr_q;
        next_ptr = 32'(grant_idx) + 1;
        if (next_ptr >= num_lce_p) begin
            next_ptr = 0;
        end
        if (grant) begin
            state_d  = FULL;
            data_d   = grant_data;
            id_d     = grant_idx;
            rr_ptr_d = lg_lce_lp'(next_ptr);
        end else if ((state_q == FULL) && lce_req_yumi_i) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q  <= EMPTY;
            data_q   <= '0;
            id_q     <= '0;
            rr_ptr_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            id_q     <= id_d;
            rr_ptr_q <= rr_ptr_d;
            ready_q  <= ready_d;
        end
    end

    assign lce_req_o   = data_q;
    assign lce_req_v_o = (state_q == FULL);
    assign grant_id_o  = id_q;

endmodule

// File: tb/tb_bp_me_lce_req_arbiter.sv
// Directed bench for the LCE request arbiter: a 4-source instance for
// round-robin/backpressure/freeze/reset and a 2-source instance for wrap.
module tb_bp_me_lce_req_arbiter;

    logic        clk;
    logic        reset_n;
    logic        freeze;

    logic [31:0] d4;
    logic [3:0]  v4;
    logic [3:0]  yumi4_o;
    logic [7:0]  req4_o;
    logic        v4_o;
    logic        yumi4_i;
    logic [1:0]  id4_o;

    logic [15:0] d2;
    logic [1:0]  v2;
    logic [1:0]  yumi2_o;
    logic [7:0]  req2_o;
    logic        v2_o;
    logic        yumi2_i;
    logic [0:0]  id2_o;

    int          n_vec;
    int          n_err;

    bp_me_lce_req_arbiter #(.num_lce_p(4), .lce_req_width_p(8)) u_dut4 (
        .clk_i          (clk),
        .reset_i        (reset_n),
        .freeze_i       (freeze),
        .lce_req_i      (d4),
        .lce_req_v_i    (v4),
        .lce_req_yumi_o (yumi4_o),
        .lce_req_o      (req4_o),
        .lce_req_v_o    (v4_o),
        .lce_req_yumi_i (yumi4_i),
        .grant_id_o     (id4_o)
    );

    bp_me_lce_req_arbiter #(.num_lce_p(2), .lce_req_width_p(8)) u_dut2 (
        .clk_i          (clk),
        .reset_i        (reset_n),
        .freeze_i       (1'b0),
        .lce_req_i      (d2),
        .lce_req_v_i    (v2),
        .lce_req_yumi_o (yumi2_o),
        .lce_req_o      (req2_o),
        .lce_req_v_o    (v2_o),
        .lce_req_yumi_i (yumi2_i),
        .grant_id_o     (id2_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        reset_n = 1'b0;
        freeze  = 1'b0;
        d4      = {8'h13, 8'h12, 8'h11, 8'h10};
        v4      = 4'b1111;
        yumi4_i = 1'b0;
        d2      = {8'hA5, 8'h3C};
        v2      = 2'b00;
        yumi2_i = 1'b0;

        #1;
        check("rst_v4", 32'(v4_o), 32'h0);
        check("rst_yumi4", 32'(yumi4_o), 32'h0);
        check("rst_id4", 32'(id4_o), 32'h0);
        check("rst_data4", 32'(req4_o), 32'h0);
        check("rst_v2", 32'(v2_o), 32'h0);
        check("rst_yumi2", 32'(yumi2_o), 32'h0);

        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rel_no_grant", 32'(yumi4_o), 32'h0);

        @(negedge clk); #1;
        check("first_grant", 32'(yumi4_o), 32'h1);
        check("first_v_lat", 32'(v4_o), 32'h0);

        // round robin 0,1,2,3,0,1 with continuous consume
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            yumi4_i = 1'b1;
            #1;
            check("rr_v", 32'(v4_o), 32'h1);
            check("rr_id", 32'(id4_o), 32'(i % 4));
            check("rr_data", 32'(req4_o), 32'(8'h10 + (i % 4)));
            check("rr_yumi", 32'(yumi4_o), 32'(1 << ((i + 1) % 4)));
        end

        // backpressure with id 2 buffered
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            yumi4_i = 1'b0;
            #1;
            check("bp_v", 32'(v4_o), 32'h1);
            check("bp_id", 32'(id4_o), 32'h2);
            check("bp_data", 32'(req4_o), 32'h12);
            check("bp_yumi", 32'(yumi4_o), 32'h0);
        end
        @(negedge clk);
        yumi4_i = 1'b1;
        #1;
        check("bp_release", 32'(yumi4_o), 32'h8);

        // freeze drains but blocks new grants
        @(negedge clk);
        freeze = 1'b1;
        #1;
        check("frz_full_id", 32'(id4_o), 32'h3);
        check("frz_yumi", 32'(yumi4_o), 32'h0);
        @(negedge clk);
        yumi4_i = 1'b0;
        #1;
        check("frz_drain_v", 32'(v4_o), 32'h0);
        check("frz_yumi2", 32'(yumi4_o), 32'h0);
        @(negedge clk); #1;
        check("frz_hold", 32'(yumi4_o), 32'h0);
        freeze = 1'b0;
        #1;
        check("unfrz_grant", 32'(yumi4_o), 32'h1);

        // asynchronous reset in the middle of a cycle while full
        @(negedge clk); #1;
        check("pre_rst_v", 32'(v4_o), 32'h1);
        check("pre_rst_id", 32'(id4_o), 32'h0);
        #1;
        reset_n = 1'b0;
        v4      = 4'b1000;
        #1;
        check("arst_v", 32'(v4_o), 32'h0);
        check("arst_id", 32'(id4_o), 32'h0);
        check("arst_data", 32'(req4_o), 32'h0);
        check("arst_yumi", 32'(yumi4_o), 32'h0);
        #10;
        reset_n = 1'b1;
        #1;
        check("arst_rel_no_grant", 32'(yumi4_o), 32'h0);
        @(negedge clk); #1;
        check("arst_grant3", 32'(yumi4_o), 32'h8);
        @(negedge clk); #1;
        check("arst_v_after", 32'(v4_o), 32'h1);
        check("arst_id_after", 32'(id4_o), 32'h3);
        check("arst_data_after", 32'(req4_o), 32'h13);

        // two-source instance: single source then pointer wrap
        @(negedge clk);
        v2      = 2'b10;
        yumi2_i = 1'b1;
        #1;
        check("s2_yumi", 32'(yumi2_o), 32'h2);
        check("s2_v0", 32'(v2_o), 32'h0);
        @(negedge clk);
        v2 = 2'b11;
        #1;
        check("s2_v1", 32'(v2_o), 32'h1);
        check("s2_data", 32'(req2_o), 32'hA5);
        check("s2_id", 32'(id2_o), 32'h1);
        check("s2_wrap_yumi", 32'(yumi2_o), 32'h1);
        @(negedge clk); #1;
        check("s2_id0", 32'(id2_o), 32'h0);
        check("s2_data0", 32'(req2_o), 32'h3C);
        check("s2_next_yumi", 32'(yumi2_o), 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
